// File: rtl/hex_scan_display_if.sv
// Bus between a 16-bit result producer and the multiplexed hex display.
// The master drives the value, dot requests and enable; the display drives the panel pins.
interface hex_scan_display_if;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        enable;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output data, dp_in, enable, input an, seg, dp);
  modport slave  (input data, dp_in, enable, output an, seg, dp);
endinterface

// File: rtl/hex_scan_display.sv
// Time-multiplexed 4-digit hex driver for a common-anode 7-segment panel.
// The value is snapshotted once per full scan so all four digits agree.
module hex_scan_display #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input logic               clk,
  input logic               rst,
  hex_scan_display_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [15:0]      shadow;
  logic             primed;
  logic             terminal;
  logic [3:0]       nib;
  logic             upper_zero;
  logic             blank;
  logic [6:0]       hex_seg;

  assign terminal = bus.enable && (div_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else if (bus.enable) begin
      if (div_cnt == LAST_CNT) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

  // A fresh snapshot is taken right after reset, then only on the wrap back to digit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= 16'h0000;
      primed <= 1'b0;
    end else if (!primed) begin
      shadow <= bus.data;
      primed <= 1'b1;
    end else if (terminal && (idx == 2'd3)) begin
      shadow <= bus.data;
    end
  end

  assign nib = shadow[{idx, 2'b00} +: 4];

  always_comb begin
    upper_zero = 1'b0;
    case (idx)
      2'd1:    upper_zero = (shadow[15:4] == 12'h000);
      2'd2:    upper_zero = (shadow[15:8] == 8'h00);
      2'd3:    upper_zero = (shadow[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
  end

  assign blank = BLANK_LEADING && (idx != 2'd0) && upper_zero;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    hex_seg = 7'b1111111;
    case (nib)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      4'hF: hex_seg = 7'b0001110;
      default: hex_seg = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.an  <= 4'b1111;
      bus.seg <= 7'b1111111;
      bus.dp  <= 1'b1;
    end else if (!bus.enable) begin
      bus.an  <= 4'b1111;
      bus.seg <= 7'b1111111;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= ~(4'b0001 << idx);
      bus.seg <= blank ? 7'b1111111 : hex_seg;
      bus.dp  <= ~bus.dp_in[idx];
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// Bench for hex_scan_display: two instances (leading-zero blanking off/on) share one
// stimulus and are checked every cycle against a count-based model plus literal vectors.
module tb_hex_scan_display;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic        enable = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;

  hex_scan_display_if bus_nb ();
  hex_scan_display_if bus_bl ();

  assign bus_nb.data   = data;
  assign bus_nb.dp_in  = dp_in;
  assign bus_nb.enable = enable;
  assign bus_bl.data   = data;
  assign bus_bl.dp_in  = dp_in;
  assign bus_bl.enable = enable;

  hex_scan_display #(.REFRESH_DIV(R), .BLANK_LEADING(1'b0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb)
  );

  hex_scan_display #(.REFRESH_DIV(R), .BLANK_LEADING(1'b1)) dut_bl (
    .clk (clk),
    .rst (rst),
    .bus (bus_bl)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex_code(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return tbl[n];
  endfunction

  // Digit on show is a pure function of how many enabled cycles have elapsed.
  function automatic int digit_of(input int cnt);
    return (cnt / R) % 4;
  endfunction

  function automatic logic [3:0] model_an(input int cnt, input logic en);
    if (!en) return 4'b1111;
    return 4'b1111 & ~(4'b0001 << digit_of(cnt));
  endfunction

  function automatic logic [6:0] model_seg(input logic [15:0] v, input int cnt,
                                           input logic en, input bit bl);
    int d;
    logic [15:0] upper;
    if (!en) return 7'b1111111;
    d = digit_of(cnt);
    upper = v >> (4 * d);
    if (bl && d != 0 && upper == 16'h0000) return 7'b1111111;
    return hex_code(upper[3:0]);
  endfunction

  function automatic logic model_dp(input logic [3:0] req, input int cnt, input logic en);
    if (!en) return 1'b1;
    return ~req[digit_of(cnt)];
  endfunction

  int          m_cnt;
  logic [15:0] m_shadow;
  logic        m_primed;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg_nb;
  logic [6:0]  exp_seg_bl;
  logic        exp_dp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt      <= 0;
      m_shadow   <= 16'h0000;
      m_primed   <= 1'b0;
      exp_an     <= 4'b1111;
      exp_seg_nb <= 7'b1111111;
      exp_seg_bl <= 7'b1111111;
      exp_dp     <= 1'b1;
    end else begin
      exp_an     <= model_an(m_cnt, enable);
      exp_seg_nb <= model_seg(m_shadow, m_cnt, enable, 1'b0);
      exp_seg_bl <= model_seg(m_shadow, m_cnt, enable, 1'b1);
      exp_dp     <= model_dp(dp_in, m_cnt, enable);
      m_primed   <= 1'b1;
      if (!m_primed || (enable && ((m_cnt + 1) % (4 * R)) == 0))
        m_shadow <= data;
      m_cnt <= m_cnt + (enable ? 1 : 0);
    end
  end

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, want %b at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    check_output("model an nb",  16'(bus_nb.an),  16'(exp_an));
    check_output("model seg nb", 16'(bus_nb.seg), 16'(exp_seg_nb));
    check_output("model dp nb",  16'(bus_nb.dp),  16'(exp_dp));
    check_output("model an bl",  16'(bus_bl.an),  16'(exp_an));
    check_output("model seg bl", 16'(bus_bl.seg), 16'(exp_seg_bl));
    check_output("model dp bl",  16'(bus_bl.dp),  16'(exp_dp));
  end

  task automatic run_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] dpr, input logic en);
    data   = d;
    dp_in  = dpr;
    enable = en;
  endtask

  task automatic do_reset(input logic [15:0] d, input logic [3:0] dpr);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(d, dpr, 1'b1);
    run_edges(2);
    rst = 1'b1;
  endtask

  initial begin
    run_edges(1);
    check_output("reset an",  16'(bus_nb.an),  16'h000F);
    check_output("reset seg", 16'(bus_nb.seg), 16'h007F);
    check_output("reset dp",  16'(bus_nb.dp),  16'h0001);

    // 12AF with blanking off: F, A, 2, 1 on digits 0..3
    do_reset(16'h12AF, 4'b0000);
    run_edges(1);
    check_output("first edge an",  16'(bus_nb.an),  16'b1110);
    check_output("first edge seg", 16'(bus_nb.seg), 16'b1000000);
    run_edges(1);
    check_output("d0 an",  16'(bus_nb.an),  16'b1110);
    check_output("d0 seg", 16'(bus_nb.seg), 16'b0001110);
    run_edges(3);
    check_output("d1 an",  16'(bus_nb.an),  16'b1101);
    check_output("d1 seg", 16'(bus_nb.seg), 16'b0001000);
    run_edges(4);
    check_output("d2 an",  16'(bus_nb.an),  16'b1011);
    check_output("d2 seg", 16'(bus_nb.seg), 16'b0100100);
    run_edges(4);
    check_output("d3 an",  16'(bus_nb.an),  16'b0111);
    check_output("d3 seg", 16'(bus_nb.seg), 16'b1111001);
    run_edges(4);
    check_output("wrap an",  16'(bus_nb.an),  16'b1110);
    check_output("wrap seg", 16'(bus_nb.seg), 16'b0001110);

    // 0005: leading digits blanked on the blanking instance only
    do_reset(16'h0005, 4'b0000);
    run_edges(2);
    check_output("0005 d0 seg bl", 16'(bus_bl.seg), 16'b0010010);
    run_edges(4);
    check_output("0005 d1 an bl",  16'(bus_bl.an),  16'b1101);
    check_output("0005 d1 seg bl", 16'(bus_bl.seg), 16'b1111111);
    check_output("0005 d1 seg nb", 16'(bus_nb.seg), 16'b1000000);

    // 0000: digit 0 still shows a zero
    do_reset(16'h0000, 4'b0000);
    run_edges(3);
    check_output("0000 d0 seg bl", 16'(bus_bl.seg), 16'b1000000);
    run_edges(11);
    check_output("0000 d3 an bl",  16'(bus_bl.an),  16'b0111);
    check_output("0000 d3 seg bl", 16'(bus_bl.seg), 16'b1111111);

    // data changes while digit 1 is on show; new value waits for the wrap
    do_reset(16'h1234, 4'b0000);
    run_edges(6);
    check_output("1234 d1 an",  16'(bus_nb.an),  16'b1101);
    check_output("1234 d1 seg", 16'(bus_nb.seg), 16'b0110000);
    apply_stimulus(16'h5678, 4'b0000, 1'b1);
    run_edges(4);
    check_output("old d2 seg", 16'(bus_nb.seg), 16'b0100100);
    run_edges(4);
    check_output("old d3 seg", 16'(bus_nb.seg), 16'b1111001);
    run_edges(4);
    check_output("new d0 an",  16'(bus_nb.an),  16'b1110);
    check_output("new d0 seg", 16'(bus_nb.seg), 16'b0000000);
    run_edges(4);
    check_output("new d1 an",  16'(bus_nb.an),  16'b1101);
    check_output("new d1 seg", 16'(bus_nb.seg), 16'b1111000);

    // disable mid-digit for 10 cycles, then resume where the scan stopped
    apply_stimulus(16'h5678, 4'b0000, 1'b0);
    run_edges(1);
    check_output("off an",  16'(bus_nb.an),  16'b1111);
    check_output("off seg", 16'(bus_nb.seg), 16'b1111111);
    check_output("off dp",  16'(bus_nb.dp),  16'b1);
    run_edges(9);
    apply_stimulus(16'h5678, 4'b0000, 1'b1);
    run_edges(1);
    check_output("resume an",  16'(bus_nb.an),  16'b1101);
    check_output("resume seg", 16'(bus_nb.seg), 16'b1111000);
    run_edges(2);
    check_output("resume d2 an",  16'(bus_nb.an),  16'b1011);
    check_output("resume d2 seg", 16'(bus_nb.seg), 16'b0000010);

    // decimal point on digit 2 only, then an asynchronous reset mid-scan
    do_reset(16'h12AF, 4'b0100);
    run_edges(5);
    check_output("dp d1", 16'(bus_nb.dp), 16'b1);
    run_edges(4);
    check_output("dp d2 an", 16'(bus_nb.an), 16'b1011);
    check_output("dp d2",    16'(bus_nb.dp), 16'b0);
    apply_stimulus(16'hC0DE, 4'b0100, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("async rst an nb",  16'(bus_nb.an),  16'b1111);
    check_output("async rst seg nb", 16'(bus_nb.seg), 16'b1111111);
    check_output("async rst dp nb",  16'(bus_nb.dp),  16'b1);
    check_output("async rst an bl",  16'(bus_bl.an),  16'b1111);
    run_edges(2);
    rst = 1'b1;
    run_edges(1);
    check_output("restart an",  16'(bus_nb.an),  16'b1110);
    check_output("restart seg", 16'(bus_nb.seg), 16'b1000000);
    run_edges(1);
    check_output("restart snap seg", 16'(bus_nb.seg), 16'b0000110);
    run_edges(20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
